ula_seq: RTL and testbench
==========================

# ula_seq

Accumulator-based command sequencer that sits on the driving side of the team's 8-bit combinational ALU. It accepts one command per handshake, presents registered operands and a function select to an external ALU instance, and captures the ALU result and overflow flag into an accumulator. It returns each result over a valid/ready response channel. This is the block that turns the ALU into a usable multi-step calculator for the lab top level.

## Interface
- NUM_BITS, 8, data width of operand, accumulator and ALU ports (two's complement)
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  command code (see Operation)
- cmd_data  in  NUM_BITS  signed operand
- alu_a  out  NUM_BITS  registered ALU operand A (always the accumulator)
- alu_b  out  NUM_BITS  registered ALU operand B (always the latched cmd_data)
- alu_f  out  2  registered ALU function: 00 AND, 01 OR, 10 ADD, 11 SUB
- alu_y  in  NUM_BITS  ALU result
- alu_ovf  in  1  ALU overflow flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  NUM_BITS  accumulator value after the command
- rsp_ovf  out  1  overflow indication (see Configuration)

## Operation
- cmd_op codes:
  - 000 LOAD: acc <= cmd_data
  - 001 AND, 010 OR, 011 ADD, 100 SUB: acc <= alu_y
  - 101 CLR: acc <= 0, overflow state cleared
  - 110/111 NOP: acc unchanged
- FSM states:
  - IDLE: cmd_ready=1. On accept, a command with codes 001–100 goes to ISSUE. Any other code updates acc immediately and goes to RESP.
  - ISSUE: alu_a/alu_b/alu_f hold the values registered at accept. At the end of the cycle, acc <= alu_y and the overflow bit <= alu_ovf for ADD/SUB or 0 for AND/OR. Next state is RESP.
  - RESP: rsp_valid=1 and rsp_data=acc. Stays in RESP until rsp_ready, then returns to IDLE.
- cmd_ready is 1 only in IDLE. No command is accepted in ISSUE or RESP.
- rsp_data and rsp_ovf stay stable while rsp_valid=1 and rsp_ready=0.
- Arithmetic wraps modulo 2^NUM_BITS. The sequencer never recomputes overflow itself; it only records alu_ovf.
- When not in ISSUE, alu_* hold their last values. No toggling occurs in IDLE.

## Timing
- Reset values: state IDLE, cmd_ready=1, acc=0, alu_a=0, alu_b=0, alu_f=00, rsp_valid=0, rsp_data=0, rsp_ovf=0.
- ALU ops: command accepted at edge k, result captured at edge k+1, rsp_valid high from edge k+1.
- LOAD/CLR/NOP: rsp_valid high from edge k, the same edge that accepts the command.
- Next accept happens no earlier than one cycle after the response handshake. Peak rate is one command per 2 cycles (LOAD/CLR/NOP) or 3 cycles (ALU ops).
- Reset asserted mid-operation returns everything to reset values immediately. Any in-flight command and pending response are discarded.
- cmd_valid in ISSUE or RESP is ignored and must be held by the producer.

## Configuration
- ULA_SEQ_STICKY_OVF_EN
  - Defined: the overflow bit is sticky. Once set by an ADD/SUB with alu_ovf=1, rsp_ovf stays 1 for all later responses until a CLR command or reset.
  - Undefined: the overflow bit is rewritten on every command. LOAD and NOP set it to 0, and rsp_ovf reflects only the current command.

## Structure
- Package ula_seq_pkg: NUM_BITS default constant, cmd_op enum (CMD_LOAD…CMD_NOP), ALU function enum (F_AND, F_OR, F_ADD, F_SUB), FSM state enum (S_IDLE, S_ISSUE, S_RESP), and a cmd-to-function mapping function.
- Single module, no sub-module. The bench instantiates the team ALU between alu_* outputs and inputs.

## Test plan
- Reset, then LOAD 100, ADD 27 → rsp_data=127, rsp_ovf=0. The ADD response appears 2 cycles after accept.
- Continue ADD 1 → rsp_data=-128 (0x80), rsp_ovf=1.
- Continue AND 0xFF → rsp_data=0x80. rsp_ovf=1 with ULA_SEQ_STICKY_OVF_EN, 0 without. Then CLR → rsp_data=0, rsp_ovf=0 in both builds.
- LOAD 0x0F, SUB 0x10 → rsp_data=-1 (0xFF), rsp_ovf=0. LOAD 0x0C, OR 0x03 → rsp_data=0x0F.
- Backpressure: hold rsp_ready=0 for 5 cycles after an ADD → rsp_valid and rsp_data are stable and cmd_ready=0 throughout. cmd_ready returns to 1 the cycle after the handshake.
- Assert reset_n=0 during ISSUE of ADD 5 (acc=10) → outputs return to reset values asynchronously. After release, acc=0 and no response is emitted.

Source files
------------

// File: rtl/ula_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ula_seq_pkg
//  Purpose  : Shared types, constants and helpers for the ula_seq command
//             sequencer (command codes, ALU functions, FSM states).
//  Revision : 1.0 - initial release
// ============================================================================
package ula_seq_pkg;

    localparam int NUM_BITS_DEFAULT = 8;

    // Command codes; 3'b111 is also decoded as NOP
    typedef enum logic [2:0] {
        CMD_LOAD = 3'd0,
        CMD_AND  = 3'd1,
        CMD_OR   = 3'd2,
        CMD_ADD  = 3'd3,
        CMD_SUB  = 3'd4,
        CMD_CLR  = 3'd5,
        CMD_NOP  = 3'd6
    } cmd_op_t;

    typedef enum logic [1:0] {
        F_AND = 2'b00,
        F_OR  = 2'b01,
        F_ADD = 2'b10,
        F_SUB = 2'b11
    } alu_f_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // Commands that need a trip through the external ALU
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op >= CMD_AND) && (op <= CMD_SUB);
    endfunction

    function automatic alu_f_t cmd_to_func(input logic [2:0] op);
        alu_f_t f;
        case (op)
            CMD_AND: f = F_AND;
            CMD_OR:  f = F_OR;
            CMD_ADD: f = F_ADD;
            default: f = F_SUB;
        endcase
        return f;
    endfunction

    // Only arithmetic functions can report a meaningful overflow
    function automatic logic func_is_arith(input alu_f_t f);
        return (f == F_ADD) || (f == F_SUB);
    endfunction

endpackage : ula_seq_pkg
`default_nettype wire

// File: rtl/ula_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ula_seq
//  Purpose  : Accumulator command sequencer driving an external 8-bit ALU.
//             Accepts one command per handshake, issues registered operands
//             to the ALU, captures result/overflow into the accumulator and
//             returns the accumulator over a valid/ready response channel.
//  Options  : ULA_SEQ_STICKY_OVF_EN - overflow bit stays set until CLR/reset.
//  Revision : 1.0 - initial release
// ============================================================================
module ula_seq
    import ula_seq_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [NUM_BITS-1:0] cmd_data,
    output logic [NUM_BITS-1:0] alu_a,
    output logic [NUM_BITS-1:0] alu_b,
    output logic [1:0]          alu_f,
    input  logic [NUM_BITS-1:0] alu_y,
    input  logic                alu_ovf,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [NUM_BITS-1:0] rsp_data,
    output logic                rsp_ovf
);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_accept;
    logic [NUM_BITS-1:0] r_acc;
    logic                r_ovf;
    logic [NUM_BITS-1:0] r_alu_a;
    logic [NUM_BITS-1:0] r_alu_b;
    alu_f_t              r_alu_f;
    logic                w_ovf_keep;   // overflow value for LOAD/NOP/AND/OR
    logic                w_ovf_issue;  // overflow value captured at end of ISSUE

`ifdef ULA_SEQ_STICKY_OVF_EN
    assign w_ovf_keep  = r_ovf;
    assign w_ovf_issue = r_ovf | (func_is_arith(r_alu_f) & alu_ovf);
`else
    assign w_ovf_keep  = 1'b0;
    assign w_ovf_issue = func_is_arith(r_alu_f) & alu_ovf;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = is_alu_op(cmd_op) ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Accumulator, overflow and ALU operand registers; ALU ports only move on accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_alu_a <= '0;
            r_alu_b <= '0;
            r_alu_f <= F_AND;
        end else if (w_accept) begin
            if (is_alu_op(cmd_op)) begin
                r_alu_a <= r_acc;
                r_alu_b <= cmd_data;
                r_alu_f <= cmd_to_func(cmd_op);
            end else begin
                case (cmd_op)
                    CMD_LOAD: begin
                        r_acc <= cmd_data;
                        r_ovf <= w_ovf_keep;
                    end
                    CMD_CLR: begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                    default: begin
                        r_ovf <= w_ovf_keep;
                    end
                endcase
            end
        end else if (r_state == S_ISSUE) begin
            r_acc <= alu_y;
            r_ovf <= w_ovf_issue;
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_f    = r_alu_f;
    assign rsp_data = r_acc;
    assign rsp_ovf  = r_ovf;

endmodule : ula_seq
`default_nettype wire

// File: tb/tb_ula_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_seq
//  Purpose  : Self-checking bench for ula_seq with a stand-in team ALU and an
//             integer-arithmetic reference model of the accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ula_seq;

    localparam logic [2:0] c_load = 3'd0;
    localparam logic [2:0] c_and  = 3'd1;
    localparam logic [2:0] c_or   = 3'd2;
    localparam logic [2:0] c_add  = 3'd3;
    localparam logic [2:0] c_sub  = 3'd4;
    localparam logic [2:0] c_clr  = 3'd5;
    localparam logic [2:0] c_nop  = 3'd6;

`ifdef ULA_SEQ_STICKY_OVF_EN
    localparam bit c_sticky = 1'b1;
`else
    localparam bit c_sticky = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_f;
    logic [7:0] alu_y;
    logic       alu_ovf;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] m_acc;
    bit         m_ovf;
    logic [7:0] last_data;
    logic       last_ovf;

    always #5 clk = ~clk;

    ula_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .alu_ovf   (alu_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf)
    );

    // Stand-in for the team combinational ALU
    always_comb begin
        alu_y   = 8'h00;
        alu_ovf = 1'b0;
        case (alu_f)
            2'b00: alu_y = alu_a & alu_b;
            2'b01: alu_y = alu_a | alu_b;
            2'b10: begin
                alu_y   = alu_a + alu_b;
                alu_ovf = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
            end
            default: begin
                alu_y   = alu_a - alu_b;
                alu_ovf = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: signed integer arithmetic with explicit range test
    task automatic model_apply(input logic [2:0] op, input logic [7:0] d);
        int s;
        bit now;
        now = 1'b0;
        case (op)
            c_load: m_acc = d;
            c_and:  m_acc = m_acc & d;
            c_or:   m_acc = m_acc | d;
            c_add, c_sub: begin
                if (op == c_add) s = int'($signed(m_acc)) + int'($signed(d));
                else             s = int'($signed(m_acc)) - int'($signed(d));
                now   = (s > 127) || (s < -128);
                m_acc = 8'(s);
            end
            c_clr:  m_acc = 8'h00;
            default: ;
        endcase
        if (op == c_clr) m_ovf = 1'b0;
        else             m_ovf = c_sticky ? (m_ovf | now) : now;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [7:0] d, input int hold);
        logic [7:0] pre_acc;
        bit         is_alu;
        int         lat;
        is_alu  = (op >= c_and) && (op <= c_sub);
        pre_acc = m_acc;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = 8'($urandom);
        model_apply(op, d);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 8) begin
            if (lat == 1 && is_alu) begin
                check("issue_alu_a", alu_a, pre_acc);
                check("issue_alu_b", alu_b, d);
                check("issue_alu_f", alu_f, 32'(op) - 1);
                check("issue_cmd_ready", cmd_ready, 0);
            end
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", lat, is_alu ? 2 : 1);
        check("rsp_data", rsp_data, m_acc);
        check("rsp_ovf", rsp_ovf, m_ovf);
        last_data = rsp_data;
        last_ovf  = rsp_ovf;
        for (int i = 0; i < hold; i++) begin
            // A pending command while busy must be ignored
            cmd_valid = 1'b1;
            cmd_op    = 3'($urandom);
            cmd_data  = 8'($urandom);
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, last_data);
            check("bp_ovf", rsp_ovf, last_ovf);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("post_cmd_ready", cmd_ready, 1);
        check("post_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'd0;
        rsp_ready = 1'b0;
        m_acc     = 8'h00;
        m_ovf     = 1'b0;
        #3;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_ovf", rsp_ovf, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_f", alu_f, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed sequence
        do_cmd(c_load, 8'd100, 0);
        do_cmd(c_add, 8'd27, 0);
        check("tp_add127_data", last_data, 8'd127);
        check("tp_add127_ovf", last_ovf, 0);
        do_cmd(c_add, 8'd1, 0);
        check("tp_wrap_data", last_data, 8'h80);
        check("tp_wrap_ovf", last_ovf, 1);
        do_cmd(c_and, 8'hFF, 0);
        check("tp_and_data", last_data, 8'h80);
        check("tp_and_ovf", last_ovf, 32'(c_sticky));
        do_cmd(c_clr, 8'h5A, 0);
        check("tp_clr_data", last_data, 0);
        check("tp_clr_ovf", last_ovf, 0);
        do_cmd(c_load, 8'h0F, 0);
        do_cmd(c_sub, 8'h10, 0);
        check("tp_sub_data", last_data, 8'hFF);
        check("tp_sub_ovf", last_ovf, 0);
        do_cmd(c_load, 8'h0C, 0);
        do_cmd(c_or, 8'h03, 0);
        check("tp_or_data", last_data, 8'h0F);
        do_cmd(c_add, 8'h21, 5);
        do_cmd(3'd7, 8'h00, 2);

        // Reset during ISSUE discards the command and its response
        do_cmd(c_load, 8'd10, 0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = c_add;
        cmd_data  = 8'd5;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_issue_cmd_ready", cmd_ready, 0);
        reset_n = 1'b0;
        #1;
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_data", rsp_data, 0);
        check("arst_alu_a", alu_a, 0);
        check("arst_alu_b", alu_b, 0);
        check("arst_alu_f", alu_f, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_acc   = 8'h00;
        m_ovf   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_rsp", rsp_valid, 0);
        end
        do_cmd(c_nop, 8'h33, 0);
        check("arst_acc_zero", last_data, 0);

        // Randomized command stream
        for (int i = 0; i < 60; i++) begin
            do_cmd(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_ula_seq
`default_nettype wire
